// File: rtl/ro_puf_pkg.sv
// Shared types and default sizing for the ring-oscillator PUF measurement path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ro_puf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_COUNT   = 2'd2,
    ST_COMPARE = 2'd3
  } state_e;

  localparam int DEF_WINDOW = 1024;
  localparam int DEF_SETTLE = 4;
  localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronises one oscillator output and counts its rising edges, saturating.
// Latency: an input edge reaches the counter 2-3 clk after it occurs (sync + history).
// Backpressure: none; edges arriving while count_en is low are dropped.
//
// Ports:
//   clk, rst_n  system clock, async active-low reset
//   ro_in       raw oscillator output (asynchronous to clk)
//   clear       synchronous clear of the counter (wins over count_en)
//   count_en    counter increments on a detected rising edge only while high
//   count       current edge count, holds at all-ones once saturated
module ro_edge_counter
  import ro_puf_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ro_in,
  input  logic             clear,
  input  logic             count_en,
  output logic [CNT_W-1:0] count
);

  // [0],[1] form the 2-flop synchroniser, [2] is the history flop.
  logic [2:0]       sync_q;
  logic             rise;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign rise = sync_q[1] & ~sync_q[2];

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && rise && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 3'b000;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[1:0], ro_in};
      cnt_q  <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/ro_pair_counter.sv
// Enables an RO pair, counts edges of each over WINDOW clk, returns a > b response.
// Latency: done pulses SETTLE+WINDOW+2 clk after start is sampled in IDLE.
// Backpressure: start is ignored (not queued) while busy; it is accepted in the done cycle.
//
// Ports:
//   clk, rst_n           system clock, async active-low reset
//   start                measurement request, sampled only in IDLE
//   ro_a_in, ro_b_in     oscillator outputs (asynchronous)
//   ro_en                oscillator enable, high through SETTLE and COUNT
//   busy, done           status; done is a one-cycle pulse with valid results
//   response, tie        count_a > count_b, count_a == count_b
//   count_a, count_b     edge counts from the last completed window
module ro_pair_counter
  import ro_puf_pkg::*;
#(
  parameter int WINDOW = DEF_WINDOW,
  parameter int SETTLE = DEF_SETTLE,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ro_a_in,
  input  logic             ro_b_in,
  output logic             ro_en,
  output logic             busy,
  output logic             done,
  output logic             response,
  output logic             tie,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b
);

  // One down-counter is shared by the settle and window phases; it only has
  // to hold the larger of the two reload values (N-1).
  localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TMR_W   = $clog2(TMR_MAX);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             ro_en_q, ro_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             resp_q, resp_d;
  logic             tie_q, tie_d;
  logic [CNT_W-1:0] res_a_q, res_a_d;
  logic [CNT_W-1:0] res_b_q, res_b_d;

  logic             cnt_clear;
  logic             cnt_en;
  logic [CNT_W-1:0] edge_cnt_a, edge_cnt_b;

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .ro_in    (ro_a_in),
    .clear    (cnt_clear),
    .count_en (cnt_en),
    .count    (edge_cnt_a)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .ro_in    (ro_b_in),
    .clear    (cnt_clear),
    .count_en (cnt_en),
    .count    (edge_cnt_b)
  );

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    resp_d    = resp_q;
    tie_d     = tie_q;
    res_a_d   = res_a_q;
    res_b_d   = res_b_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SETTLE;
          tmr_d     = TMR_W'(SETTLE - 1);
          cnt_clear = 1'b1;
          resp_d    = 1'b0;
          tie_d     = 1'b0;
          res_a_d   = '0;
          res_b_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (tmr_q == '0) begin
          state_d = ST_COUNT;
          tmr_d   = TMR_W'(WINDOW - 1);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_COUNT: begin
        cnt_en = 1'b1;
        if (tmr_q == '0) begin
          state_d = ST_COMPARE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_COMPARE: begin
        // Counters are frozen here, so they can be compared and copied directly.
        state_d = ST_IDLE;
        resp_d  = (edge_cnt_a > edge_cnt_b);
        tie_d   = (edge_cnt_a == edge_cnt_b);
        res_a_d = edge_cnt_a;
        res_b_d = edge_cnt_b;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are registered from the next state so they line up with it.
    ro_en_d = (state_d == ST_SETTLE) || (state_d == ST_COUNT);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_q == ST_COMPARE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      ro_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      resp_q  <= 1'b0;
      tie_q   <= 1'b0;
      res_a_q <= '0;
      res_b_q <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      ro_en_q <= ro_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      resp_q  <= resp_d;
      tie_q   <= tie_d;
      res_a_q <= res_a_d;
      res_b_q <= res_b_d;
    end
  end

  assign ro_en    = ro_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign response = resp_q;
  assign tie      = tie_q;
  assign count_a  = res_a_q;
  assign count_b  = res_b_q;

endmodule
